// File: rtl/om_rd_arbiter.sv
// om_rd_arbiter: owner-tagged OM read-port arbiter, max-scan (A) vs threshold (B).
// Define OM_ARB_STARVE_EN to bound how long a locked burst can hold off the other side.
module om_rd_arbiter #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 15
) (
   input  logic              iClk,
   input  logic              iReset_n,
   input  logic              iReq_a,
   input  logic [ADDR_W-1:0] iAddr_a,
   input  logic              iLock_a,
   input  logic              iReq_b,
   input  logic [ADDR_W-1:0] iAddr_b,
   input  logic              iLock_b,
   output logic              oGnt_a,
   output logic              oGnt_b,
   output logic              oRd_OM,
   output logic [ADDR_W-1:0] oAddr_OM,
   input  logic [DATA_W-1:0] iData_OM,
   output logic              oValid_a,
   output logic              oValid_b,
   output logic [DATA_W-1:0] oData
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_A = 2'd1;
   localparam logic [1:0] OWN_B = 2'd2;

   if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1) begin : g_bad_param
      $error("om_rd_arbiter: parameter out of range");
   end

   logic [1:0]        state_q, state_d;
   logic              last_b_q;
   logic              rd_q, gnt_a_q, gnt_b_q;
   logic              gnt_a_d, gnt_b_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [RD_LAT-1:0] tag_v_q, tag_b_q;

`ifdef OM_ARB_STARVE_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             wait_other;

   assign wait_other = (state_q == OWN_A && iReq_b) ||
                       (state_q == OWN_B && iReq_a);
`endif

   always_comb begin
      state_d = state_q;
      gnt_a_d = 1'b0;
      gnt_b_d = 1'b0;
      case (state_q)
         IDLE: begin
            // On contention the side that did not issue last wins
            if (iReq_a && iReq_b) begin
               gnt_a_d = last_b_q;
               gnt_b_d = !last_b_q;
            end else begin
               gnt_a_d = iReq_a;
               gnt_b_d = iReq_b;
            end
            if (gnt_a_d && iLock_a)
               state_d = OWN_A;
            else if (gnt_b_d && iLock_b)
               state_d = OWN_B;
         end
         OWN_A: begin
            gnt_a_d = iReq_a;
            if (!(iReq_a && iLock_a))
               state_d = IDLE;
         end
         OWN_B: begin
            gnt_b_d = iReq_b;
            if (!(iReq_b && iLock_b))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef OM_ARB_STARVE_EN
      starve_d = starve_q;
      if (wait_other) begin
         if (starve_q == STARVE_LIM) begin
            gnt_a_d  = (state_q == OWN_B);
            gnt_b_d  = (state_q == OWN_A);
            state_d  = IDLE;
            starve_d = '0;
         end else begin
            starve_d = starve_q + 1'b1;
         end
      end
      if (state_d == IDLE)
         starve_d = '0;
`endif
   end

   always_comb begin
      addr_d = addr_q;
      if (gnt_a_d)
         addr_d = iAddr_a;
      else if (gnt_b_d)
         addr_d = iAddr_b;
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_q  <= IDLE;
         last_b_q <= 1'b1;
         rd_q     <= 1'b0;
         gnt_a_q  <= 1'b0;
         gnt_b_q  <= 1'b0;
         addr_q   <= '0;
         tag_v_q  <= '0;
         tag_b_q  <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= gnt_a_d | gnt_b_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         addr_q  <= addr_d;
         if (gnt_a_d | gnt_b_d)
            last_b_q <= gnt_b_d;
         // Tag enters while the strobe is on the bus; tail lines up with data
         tag_v_q[0] <= rd_q;
         tag_b_q[0] <= gnt_b_q;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
            tag_b_q[i] <= tag_b_q[i-1];
         end
      end
   end

`ifdef OM_ARB_STARVE_EN
   always_ff @(posedge iClk) begin
      if (!iReset_n)
         starve_q <= '0;
      else
         starve_q <= starve_d;
   end
`endif

   assign oRd_OM   = rd_q;
   assign oGnt_a   = gnt_a_q;
   assign oGnt_b   = gnt_b_q;
   assign oAddr_OM = addr_q;
   assign oValid_a = tag_v_q[RD_LAT-1] & ~tag_b_q[RD_LAT-1];
   assign oValid_b = tag_v_q[RD_LAT-1] &  tag_b_q[RD_LAT-1];
   assign oData    = iData_OM;

endmodule

// File: doc/om_rd_arbiter.md
Name: om_rd_arbiter

Overview:
- Arbitrates the single read port of the output memory (OM) between two requesters.
- Requester A is the max-value scan controller, which reads score words to build 5x5 window sums.
- Requester B is the 17x17 threshold unit, which reads back candidate scores.
- Replaces the ad-hoc flag mux on the OM address. It issues at most one read per cycle and tags each read with its owner, so the returned data valid is routed to the correct requester after the fixed memory latency.

Parameters:
ADDR_W, 13, OM address width
DATA_W, 32, OM data width
RD_LAT, 2, cycles from oRd_OM high to iData_OM valid (legal range 1..4)
STARVE_MAX, 15, maximum cycles a waiting requester is held off by a locked burst (used only with the optional feature)

Ports:
iClk  in  1  clock
iReset_n  in  1  synchronous active-low reset
iReq_a  in  1  requester A read request
iAddr_a  in  ADDR_W  requester A address
iLock_a  in  1  A holds ownership while high (burst)
iReq_b  in  1  requester B read request
iAddr_b  in  ADDR_W  requester B address
iLock_b  in  1  B holds ownership while high
oGnt_a  out  1  A's presented request was issued this cycle
oGnt_b  out  1  B's presented request was issued this cycle
oRd_OM  out  1  OM read strobe
oAddr_OM  out  ADDR_W  OM read address
iData_OM  in  DATA_W  OM read data
oValid_a  out  1  oData belongs to A
oValid_b  out  1  oData belongs to B
oData  out  DATA_W  read data, combinational pass-through of iData_OM

Behaviour:
- Reset: iReset_n is synchronous, active-low; clock iClk. All outputs go to 0, the tag pipe is cleared, state is IDLE, last_gnt=B, and the starve counter is 0.
- Issue timing:
  - Requests are sampled at each rising edge.
  - At the next cycle oRd_OM=1, oAddr_OM=captured address, and oGnt_x=1. Outputs are registered.
- Requester protocol:
  - Hold iReq_x and iAddr_x stable until oGnt_x is seen.
  - A request still asserted in a cycle with oGnt_x=1 is a new transfer. Sustained requests therefore yield one read per cycle.
- FSM states:
  - IDLE: no owner. A single requester is granted. If both request, the one not equal to last_gnt is granted. Go to OWN_A or OWN_B if the winner's iLock is high, else stay IDLE.
  - OWN_A / OWN_B: only the owner is granted.
  - Leaving OWN_x: go to IDLE when the owner's lock is sampled low, or its iReq is sampled low. If the other side is waiting at that point, it wins the next arbitration.
- last_gnt updates on every issue.
- Return path:
  - Shift register of RD_LAT entries holding {valid, owner}, loaded at issue.
  - oValid_a/oValid_b = tail valid AND owner. They assert exactly RD_LAT cycles after the matching oRd_OM.
  - Never both high in the same cycle.
- Simultaneous events: a lock rising in the same cycle as arbitration applies only to the winner; the loser's lock is ignored until it is granted.
- Reset mid-burst: in-flight tags are dropped and no oValid is produced for them.
- No requests: oRd_OM=0, and oAddr_OM holds its last value.

Optional Feature:
- Macro: OM_ARB_STARVE_EN.
- Defined:
  - In OWN_x, a counter increments each cycle the other requester is requesting and not granted.
  - When the counter reaches STARVE_MAX, the next issue slot goes to the waiting requester, ownership is dropped (state goes to IDLE), and the counter clears.
  - The counter also clears on any grant to the waiting requester.
- Not defined: the lock is honoured indefinitely, and no counter logic is synthesised.

Test Plan:
- A requests addr 0x0010 once, RD_LAT=2, iData_OM=0xDEADBEEF: oRd_OM/oGnt_a at cycle 1 with addr 0x0010; oValid_a=1 and oData=0xDEADBEEF at cycle 3; oValid_b stays 0.
- A and B request continuously, no locks: issues alternate A,B,A,B after reset; one oRd_OM per cycle; return valids alternate correspondingly.
- A locked burst of 8 reads (0x100..0x107) while B requests: 8 consecutive A grants, then a B grant on the cycle after the lock drops; A's addresses are in order.
- Reset asserted for 1 cycle with two reads in flight: no oValid_a/oValid_b afterwards; first post-reset grant goes to A when both request.
- OM_ARB_STARVE_EN defined, STARVE_MAX=4: A holds lock with B requesting -> B granted after 4 held-off cycles, state IDLE; with the macro undefined, B is never granted while A's lock stays high.
- Single A request with RD_LAT=4: oValid_a exactly 4 cycles after oRd_OM; back-to-back A/B tags at RD_LAT=4 are delivered in issue order.
